// File: rtl/pvr_dpram_streamer_pkg.sv
// rtl/pvr_dpram_streamer_pkg.sv - shared types and constants for the PVR scratch-RAM streamer
// Purpose: state enum, RAM geometry constants and the run-length type used by
//          pvr_dpram_streamer and its stream interface. No ports.
package pvr_pkg;

  localparam int PVR_RAM_AW = 6;
  localparam int PVR_RAM_DW = 32;
  localparam int PVR_LEN_W  = 7;

  typedef logic [PVR_LEN_W-1:0] pvr_len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } streamer_state_e;

endpackage

// File: rtl/pvr_dpram_streamer_if.sv
// rtl/pvr_dpram_streamer_if.sv - valid/ready output stream of the PVR scratch-RAM streamer
// Purpose: bundles the downstream word stream (tile/ISP feed).
// Signals: out_data (DW) / out_valid / out_last driven by the master,
//          out_ready driven by the slave; a beat transfers on valid & ready.
interface pvr_dpram_streamer_if
  import pvr_pkg::*;
#(
  parameter int DW = PVR_RAM_DW
);

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/pvr_fwft_fifo.sv
// rtl/pvr_fwft_fifo.sv - first-word-fall-through register FIFO with flush
// Purpose: small output buffer; head_o always shows the oldest entry.
// Ports: clk, reset_n (async, active-low); push_i/push_data_i write an entry;
//        pop_i removes the head; flush_i empties the FIFO (wins over push/pop);
//        head_o is the oldest entry, count_o the number of stored entries.
module pvr_fwft_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] head_o,
  output logic [CW-1:0] count_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [IW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(DEPTH - 1)) ? '0 : idx + IW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= next_idx(wr_q);
      end
      if (do_pop) rd_q <= next_idx(rd_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/pvr_dpram_streamer.sv
// rtl/pvr_dpram_streamer.sv - read-side streamer for the 64x32 dual-port PVR scratch RAM
// Purpose: on start, reads len words from base (address wraps) and streams them out,
//          hiding the RAM's registered read latency behind a credit-checked FIFO.
// Ports: clk, reset_n (async, active-low); start/base/len/abort control;
//        busy/done status; ram_addr/ram_re/ram_q read port, ram_we/ram_data tied off;
//        out: valid/ready stream (master modport).
module pvr_dpram_streamer
  import pvr_pkg::*;
#(
  parameter int DW         = PVR_RAM_DW,
  parameter int AW         = PVR_RAM_AW,
  parameter int LW         = PVR_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q,
  output logic          ram_re,
  pvr_dpram_streamer_if.master out
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  streamer_state_e state_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   issue_cnt_q;
  logic [LW-1:0]   beat_cnt_q;
  logic            q_valid_q;

  logic [CW-1:0]   fifo_count;
  logic [DW-1:0]   fifo_head;
  logic [CW:0]     occupancy;
  logic            issue, fire, abort_hit;

  assign abort_hit = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  // Credit check: a word already read but not yet pushed (q_valid_q) still
  // owns a FIFO slot, so a new read is issued only if a slot is free for it too.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, q_valid_q};
  assign issue     = (state_q == ST_RUN) && (issue_cnt_q != '0) && (occupancy < DEPTH_L);

  assign out.out_valid = (fifo_count != '0);
  assign out.out_data  = fifo_head;
  assign out.out_last  = out.out_valid && (beat_cnt_q == LW'(1));
  assign fire          = out.out_valid && out.out_ready;

  pvr_fwft_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (q_valid_q),
    .push_data_i (ram_q),
    .pop_i       (fire),
    .flush_i     (abort_hit),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      q_valid_q   <= 1'b0;
    end else begin
      // An abort drops the read that is still on its way out of the RAM.
      q_valid_q <= issue && !abort_hit;
      if (issue) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        issue_cnt_q <= issue_cnt_q - LW'(1);
      end
      if (fire) beat_cnt_q <= beat_cnt_q - LW'(1);

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rd_ptr_q    <= base;
            issue_cnt_q <= len;
            beat_cnt_q  <= len;
            state_q     <= (len != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (abort) state_q <= ST_DONE;
          else if (issue_cnt_q == '0) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (abort) state_q <= ST_DONE;
          else if (fire && (beat_cnt_q == LW'(1))) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign ram_addr = rd_ptr_q;
  assign ram_re   = issue;
  assign ram_we   = 1'b0;
  assign ram_data = '0;

endmodule
